// File: rtl/rect_plot_scheduler.sv
// Round-robin scheduler: grants one of three rectangle requesters and rasters it to the vga_adapter at one pixel per cycle.
// First pixel appears the cycle after req is seen in IDLE; other requesters stay unacked until the FSM returns to IDLE.
module rect_plot_scheduler #(
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [23:0] x0,
  input  logic [20:0] y0,
  input  logic [11:0] wm1,
  input  logic [11:0] hm1,
  input  logic [8:0]  colour_in,
  output logic [2:0]  ack,
  output logic [2:0]  done,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        plot,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] owner, last_owner, grant;
  logic [1:0] cand0, cand1, cand2;
  logic [7:0] x0r;
  logic [6:0] y0r;
  logic [3:0] wm1r, hm1r, xc, yc;
  logic [2:0] colr;
  logic [8:0] xsum;
  logic [7:0] ysum;
  logic       row_end, last_pix;

  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Search order starts just after the previous owner.
  always_comb begin
    cand0 = rr_next(last_owner);
    cand1 = rr_next(cand0);
    cand2 = rr_next(cand1);
    if (req[cand0])      grant = cand0;
    else if (req[cand1]) grant = cand1;
    else                 grant = cand2;
  end

  assign xsum     = {1'b0, x0r} + {5'd0, xc};
  assign ysum     = {1'b0, y0r} + {4'd0, yc};
  assign row_end  = (xc == wm1r);
  assign last_pix = row_end && (yc == hm1r);

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      owner      <= 2'd0;
      last_owner <= 2'd2;
      x0r        <= '0;
      y0r        <= '0;
      wm1r       <= '0;
      hm1r       <= '0;
      colr       <= '0;
      xc         <= '0;
      yc         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 3'b000) begin
            owner <= grant;
            x0r   <= x0[grant*8 +: 8];
            y0r   <= y0[grant*7 +: 7];
            wm1r  <= wm1[grant*4 +: 4];
            hm1r  <= hm1[grant*4 +: 4];
            colr  <= colour_in[grant*3 +: 3];
            xc    <= '0;
            yc    <= '0;
          end
        end
        DRAW: begin
          if (row_end) begin
            xc <= '0;
            yc <= yc + 4'd1;
          end else begin
            xc <= xc + 4'd1;
          end
        end
        DONE: last_owner <= owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    ack        = 3'b000;
    done       = 3'b000;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    plot       = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (req != 3'b000) state_nxt = DRAW;
      end
      DRAW: begin
        busy       = 1'b1;
        vga_x      = xsum[7:0];
        vga_y      = ysum[6:0];
        vga_colour = colr;
        plot       = (int'(xsum) < XSCREEN) && (int'(ysum) < YSCREEN);
        // Pixel (0,0) is only ever visited on the first DRAW cycle.
        if (xc == 4'd0 && yc == 4'd0) ack = 3'b001 << owner;
        if (last_pix) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 3'b001 << owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs are quiet for the whole reset cycle, not just after the edge.
    if (reset) begin
      ack        = 3'b000;
      done       = 3'b000;
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      plot       = 1'b0;
      busy       = 1'b0;
    end
  end

endmodule

// File: tb/tb_rect_plot_scheduler.sv
// Scoreboarded bench: a rectangle-level model queues expected acks, pixels and dones; a monitor checks what the DUT presents.
module tb_rect_plot_scheduler;

  logic        CLOCK_50;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] x0;
  logic [20:0] y0;
  logic [11:0] wm1, hm1;
  logic [8:0]  colour_in;
  logic [2:0]  ack, done;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot, busy;

  rect_plot_scheduler #(.XSCREEN(160), .YSCREEN(120)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .req(req), .x0(x0), .y0(y0),
    .wm1(wm1), .hm1(hm1), .colour_in(colour_in), .ack(ack), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot), .busy(busy)
  );

  typedef struct { int stamp; int who; } ev_t;
  typedef struct { int stamp; int x; int y; int c; } pix_t;

  ev_t  ack_q[$], done_q[$];
  pix_t pix_q[$];

  int compared = 0;
  int mism     = 0;
  int cyc      = 0;
  int bstart   = 0;
  int bend     = -1;
  int idle_from = 0;
  int last_g   = 2;

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: on each edge, looks at the inputs of the cycle just ended.
  initial begin
    int c, g, xo, yo, w, h, col, wh;
    forever begin
      @(posedge CLOCK_50);
      c   = cyc;
      cyc = cyc + 1;
      if (reset) begin
        ack_q.delete(); done_q.delete(); pix_q.delete();
        last_g = 2; bend = -1; idle_from = c + 1;
      end else if (c >= idle_from && req != 3'b000) begin
        g = (last_g + 1) % 3;
        while (!req[g]) g = (g + 1) % 3;
        last_g = g;
        xo  = int'((x0 >> (8 * g)) & 24'hFF);
        yo  = int'((y0 >> (7 * g)) & 21'h7F);
        w   = int'((wm1 >> (4 * g)) & 12'hF) + 1;
        h   = int'((hm1 >> (4 * g)) & 12'hF) + 1;
        col = int'((colour_in >> (3 * g)) & 9'h7);
        wh  = w * h;
        ack_q.push_back('{c + 1, g});
        for (int i = 0; i < h; i++)
          for (int j = 0; j < w; j++)
            if (xo + j < 160 && yo + i < 120)
              pix_q.push_back('{c + 1 + i * w + j, xo + j, yo + i, col});
        done_q.push_back('{c + 1 + wh, g});
        bstart    = c + 1;
        bend      = c + 1 + wh;
        idle_from = c + 2 + wh;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the queue heads.
  initial begin
    int n;
    logic exp_busy;
    forever begin
      @(negedge CLOCK_50);
      n = cyc;
      if (reset) begin
        check("reset_out", {ack, done, plot, busy, vga_x, vga_y, vga_colour}, 32'd0);
      end else begin
        exp_busy = (n >= bstart && n <= bend);
        check("busy", {31'd0, busy}, {31'd0, exp_busy});
        if (!exp_busy || done != 3'b000)
          check("idle_vga", {plot, vga_x, vga_y, vga_colour}, 32'd0);
        while (ack_q.size() > 0 && ack_q[0].stamp < n) begin
          check("ack_missed", ack_q[0].stamp, n); void'(ack_q.pop_front());
        end
        while (done_q.size() > 0 && done_q[0].stamp < n) begin
          check("done_missed", done_q[0].stamp, n); void'(done_q.pop_front());
        end
        while (pix_q.size() > 0 && pix_q[0].stamp < n) begin
          check("pixel_missed", pix_q[0].stamp, n); void'(pix_q.pop_front());
        end
        if (ack != 3'b000) begin
          if (ack_q.size() > 0 && ack_q[0].stamp == n) begin
            check("ack", ack, 32'd1 << ack_q[0].who); void'(ack_q.pop_front());
          end else check("ack_unexpected", ack, 32'd0);
        end
        if (done != 3'b000) begin
          if (done_q.size() > 0 && done_q[0].stamp == n) begin
            check("done", done, 32'd1 << done_q[0].who); void'(done_q.pop_front());
          end else check("done_unexpected", done, 32'd0);
        end
        if (plot) begin
          if (pix_q.size() > 0 && pix_q[0].stamp == n) begin
            check("pixel", {vga_x, vga_y, vga_colour},
                  (pix_q[0].x << 10) | (pix_q[0].y << 3) | pix_q[0].c);
            void'(pix_q.pop_front());
          end else check("pixel_unexpected", {vga_x, vga_y, vga_colour}, 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int k);
    repeat (k) begin @(posedge CLOCK_50); #1; end
  endtask

  task automatic set_lane(input int i, input int x, input int y, input int w1, input int h1, input int c);
    x0[8*i +: 8]        = 8'(x);
    y0[7*i +: 7]        = 7'(y);
    wm1[4*i +: 4]       = 4'(w1);
    hm1[4*i +: 4]       = 4'(h1);
    colour_in[3*i +: 3] = 3'(c);
  endtask

  task automatic rand_lanes();
    x0 = 24'($urandom); y0 = 21'($urandom); wm1 = 12'($urandom);
    hm1 = 12'($urandom); colour_in = 9'($urandom);
  endtask

  initial begin
    reset = 1'b1; req = 3'b000;
    x0 = '0; y0 = '0; wm1 = '0; hm1 = '0; colour_in = '0;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Single 16x16 rectangle from requester 0
    set_lane(0, 95, 40, 15, 15, 4);
    req = 3'b001; tick(1); req = 3'b000; tick(262);

    // Contention: all three held, small rectangles
    set_lane(0, 10, 10, 1, 1, 1); set_lane(1, 20, 20, 2, 0, 2); set_lane(2, 30, 30, 0, 2, 3);
    req = 3'b111; tick(30); req = 3'b000; tick(20);

    // Clipping at the bottom-right corner
    set_lane(1, 155, 118, 7, 7, 6);
    req = 3'b010; tick(1); req = 3'b000; tick(70);

    // Minimum rectangle
    set_lane(2, 0, 0, 0, 0, 7);
    req = 3'b100; tick(1); req = 3'b000; tick(5);

    // Mid-draw reset at pixel 37 of a 4x16 rectangle, then a normal request
    set_lane(0, 50, 50, 3, 15, 5);
    req = 3'b001; tick(1); req = 3'b000; tick(37);
    reset = 1'b1; tick(1); reset = 1'b0;
    set_lane(1, 60, 60, 2, 2, 3);
    req = 3'b010; tick(1); req = 3'b000; tick(15);

    // Input churn during DRAW
    set_lane(1, 100, 80, 7, 3, 2);
    req = 3'b010; tick(1);
    for (int i = 0; i < 40; i++) begin
      x0 = 24'($urandom); colour_in = 9'($urandom); req = {1'b0, 1'($urandom), 1'b0};
      tick(1);
    end
    req = 3'b000; tick(262);

    // Randomized traffic with occasional resets
    for (int it = 0; it < 40; it++) begin
      rand_lanes();
      req = 3'($urandom_range(1, 7));
      for (int k = 0; k < int'($urandom_range(1, 30)); k++) begin
        if ($urandom_range(0, 3) == 0) rand_lanes();
        tick(1);
      end
      if ($urandom_range(0, 9) == 0) begin reset = 1'b1; tick(1); reset = 1'b0; end
      req = 3'b000;
      tick($urandom_range(0, 40));
    end

    req = 3'b000; tick(300);
    check("queues_empty", ack_q.size() + done_q.size() + pix_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/rect_plot_scheduler.md
RECT_PLOT_SCHEDULER -- requirements
Module: rect_plot_scheduler

Interface
REQ-001 SHALL have parameter XSCREEN, default 160, meaning framebuffer width in pixels (clip limit for x).
REQ-002 SHALL have parameter YSCREEN, default 120, meaning framebuffer height in pixels (clip limit for y).
REQ-003 SHALL have port CLOCK_50  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  3  per-requester rectangle request; bit i belongs to requester i.
REQ-006 SHALL have port x0  input  24  rectangle origin x; requester i on bits [8i+7:8i].
REQ-007 SHALL have port y0  input  21  rectangle origin y; requester i on bits [7i+6:7i].
REQ-008 SHALL have port wm1  input  12  rectangle width minus 1; requester i on bits [4i+3:4i], giving widths 1..16.
REQ-009 SHALL have port hm1  input  12  rectangle height minus 1; requester i on bits [4i+3:4i], giving heights 1..16.
REQ-010 SHALL have port colour_in  input  9  rectangle colour, 3-bit RGB; requester i on bits [3i+2:3i].
REQ-011 SHALL have port ack  output  3  one-cycle pulse; the request was captured.
REQ-012 SHALL have port done  output  3  one-cycle pulse; the owner's rectangle is fully scanned.
REQ-013 SHALL have port vga_x  output  8  pixel x to the vga_adapter.
REQ-014 SHALL have port vga_y  output  7  pixel y to the vga_adapter.
REQ-015 SHALL have port vga_colour  output  3  pixel colour to the vga_adapter.
REQ-016 SHALL have port plot  output  1  pixel write enable to the vga_adapter.
REQ-017 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 SHALL implement a three-state FSM with states IDLE, DRAW and DONE.
REQ-019 In IDLE with req != 0, the FSM SHALL move to DRAW at the next edge, grant exactly one requester g, and capture x0, y0, wm1, hm1 and colour of g into internal registers.
REQ-020 Grant SHALL be round-robin: search order starts at (last_owner+1) mod 3, and last_owner SHALL update to g on DONE.
REQ-021 ack[g] SHALL be high only during the first DRAW cycle; ack SHALL be 0 at all other times.
REQ-022 req SHALL be sampled only in IDLE; req changes in DRAW or DONE SHALL have no effect.
REQ-023 A req still high on return to IDLE SHALL be treated as a new request.
REQ-024 DRAW SHALL produce one pixel per cycle in raster order using column counter xc and row counter yc, both starting at 0.
REQ-025 Each DRAW cycle, xc SHALL increment; when xc==wm1, xc SHALL clear to 0 and yc SHALL increment.
REQ-026 When xc==wm1 and yc==hm1, the FSM SHALL go to DONE; DRAW SHALL last exactly (wm1+1)*(hm1+1) cycles.
REQ-027 In DRAW, vga_x SHALL equal the low 8 bits of x0r+xc, vga_y the low 7 bits of y0r+yc, and vga_colour the captured colour.
REQ-028 Sums x0r+xc and y0r+yc SHALL be computed at 9 and 8 bits respectively.
REQ-029 In DRAW, plot SHALL be 1 iff the 9-bit x sum < XSCREEN and the 8-bit y sum < YSCREEN.
REQ-030 Clipped pixels SHALL still consume their cycle, and the scan SHALL continue.
REQ-031 In DONE, done[owner] SHALL be 1 and plot SHALL be 0; the FSM SHALL return to IDLE next cycle.
REQ-032 Minimum spacing between consecutive acks SHALL be w*h+2 cycles.
REQ-033 Latency from req seen in IDLE to the first pixel SHALL be 1 cycle, since the first DRAW cycle plots pixel (0,0).
REQ-034 In IDLE and DONE, plot SHALL be 0, and vga_x, vga_y and vga_colour SHALL be 0.
REQ-035 Captured rectangle parameters SHALL remain stable for the whole DRAW phase regardless of input changes.

Reset
REQ-036 reset SHALL, at the next edge and in any state, force IDLE, set xc=yc=0 and last_owner=2 (requester 0 wins first), and clear all captured registers.
REQ-037 While in reset, outputs SHALL be ack=0, done=0, plot=0, busy=0, vga_x=0, vga_y=0, vga_colour=0.
REQ-038 reset during DRAW SHALL abort the rectangle with no done pulse, and the aborted requester SHALL retain no priority.

Verification
REQ-039 Single request: req=001, x0=95, y0=40, w=h=16 (wm1=hm1=15), colour 3'b100 -> ack[0] on cycle 1; 256 plot cycles covering x 95..110, y 40..55 in raster order; done[0] one cycle later; busy low after.
REQ-040 Contention: req=111 held continuously after reset -> ack order 0,1,2,0; each ack exactly 1 cycle, no two pulses overlap.
REQ-041 Clipping: x0=155, y0=118, w=h=8 -> 64 DRAW cycles, plot high for exactly 10 pixels (x 155..159, y 118..119), done[i] after cycle 64.
REQ-042 Minimum rectangle: wm1=hm1=0 -> one DRAW cycle with plot=1; cycle sequence ack, done, IDLE, spanning 3 cycles total.
REQ-043 Mid-draw reset: reset for 1 cycle at pixel 37 of a 4x16 rectangle -> next cycle plot=0, busy=0, no done; a following req=010 is acked normally.
REQ-044 Input churn: during DRAW, change x0, colour_in and req of the owner -> output pixels unchanged from the captured values.
